// File: rtl/multicycle_control_unit_if.sv
// Instruction and memory handshake bundle for the multi-cycle control unit.
// The master side drives instructions and memory acknowledges; the slave side is the sequencer.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 3
);
  logic                en;
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                instr_ready;
  logic                mem_ack;
  logic                mem_req;
  logic [OPCODE_W-1:0] alu_op;
  logic                en_write_reg;
  logic                en_write_mem;
  logic                pc_inc;
  logic                busy;
  logic                halted;
  logic                timeout_err;

  modport master (
    output en, instr_valid, opcode, mem_ack,
    input  instr_ready, mem_req, alu_op, en_write_reg, en_write_mem,
           pc_inc, busy, halted, timeout_err
  );

  modport slave (
    input  en, instr_valid, opcode, mem_ack,
    output instr_ready, mem_req, alu_op, en_write_reg, en_write_mem,
           pc_inc, busy, halted, timeout_err
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: IDLE -> DECODE -> EXECUTE -> (MEM) -> WB, with HALT.
// Outputs are a Moore decode of the registered state, so an async reset clears them at once.
module multicycle_control_unit #(
  parameter int                  OPCODE_W    = 3,
  parameter logic [OPCODE_W-1:0] OP_LOAD     = 3'b110,
  parameter logic [OPCODE_W-1:0] OP_MEM_LO   = 3'b010,
  parameter logic [OPCODE_W-1:0] OP_MEM_HI   = 3'b101,
  parameter logic [OPCODE_W-1:0] OP_HALT     = 3'b111,
  parameter int                  MEM_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_unit_if.slave    bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] EXECUTE = 3'd2;
  localparam logic [2:0] MEM     = 3'd3;
  localparam logic [2:0] WB      = 3'd4;
  localparam logic [2:0] HALT    = 3'd5;

  localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [2:0]          state_r;
  logic [OPCODE_W-1:0] op_r;
  logic [OPCODE_W-1:0] alu_op_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                timeout_err_r;
  logic                is_mem_s;

  logic ready_s, mem_req_s, wr_mem_s, wr_reg_s, pc_inc_s, busy_s, halted_s;

  assign is_mem_s = (op_r >= OP_MEM_LO) && (op_r <= OP_MEM_HI);

  // Sequencer state, latched opcode, ALU op, MEM wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      op_r          <= '0;
      alu_op_r      <= '0;
      cnt_r         <= '0;
      timeout_err_r <= 1'b0;
    end else if (bus.en) begin
      case (state_r)
        IDLE: begin
          if (bus.instr_valid) begin
            op_r    <= bus.opcode;
            state_r <= DECODE;
          end
        end
        DECODE: begin
          if (op_r == OP_HALT) begin
            state_r <= HALT;
          end else begin
            alu_op_r <= op_r;
            state_r  <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (is_mem_s) begin
            cnt_r   <= '0;
            state_r <= MEM;
          end else begin
            state_r <= WB;
          end
        end
        MEM: begin
          cnt_r <= cnt_r + CNT_W'(1);
          // An acknowledge arriving on the final allowed cycle still counts as success
          if (bus.mem_ack) begin
            state_r <= WB;
          end else if (cnt_r == CNT_LAST) begin
            timeout_err_r <= 1'b1;
            state_r       <= WB;
          end
        end
        WB:      state_r <= IDLE;
        HALT:    state_r <= HALT;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    ready_s   = 1'b0;
    mem_req_s = 1'b0;
    wr_mem_s  = 1'b0;
    wr_reg_s  = 1'b0;
    pc_inc_s  = 1'b0;
    busy_s    = 1'b1;
    halted_s  = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      DECODE, EXECUTE: begin
        busy_s = 1'b1;
      end
      MEM: begin
        mem_req_s = 1'b1;
        wr_mem_s  = 1'b1;
      end
      WB: begin
        pc_inc_s = 1'b1;
        wr_reg_s = (op_r == OP_LOAD);
      end
      HALT: begin
        busy_s   = 1'b0;
        halted_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign bus.instr_ready  = ready_s;
  assign bus.mem_req      = mem_req_s;
  assign bus.en_write_mem = wr_mem_s;
  assign bus.en_write_reg = wr_reg_s;
  assign bus.pc_inc       = pc_inc_s;
  assign bus.busy         = busy_s;
  assign bus.halted       = halted_s;
  assign bus.alu_op       = alu_op_r;
  assign bus.timeout_err  = timeout_err_r;

endmodule
